jtcps1_colour: RTL and testbench
================================

Name: jtcps1_colour

Overview:
- Colour stage directly downstream of the tilemap/sprite mixer inside jtcps1_video.
- Palette DMA: on request, copies palette words from VRAM (via a jtframe_sdram_mux read slot) into internal dual-port palette RAM during vertical blank.
- Pixel path: per pixel, turns a mixer palette index into brightness-scaled 8-bit RGB with blanking applied.

Parameters:
- PAL_AW, 11, palette index width; palette holds 2**PAL_AW 16-bit words; DMA copies exactly that many.

Ports:
- clk  in  1  system clock (48 MHz)
- rst  in  1  synchronous reset, active high
- pxl_cen  in  1  pixel clock enable (cen8)
- VB  in  1  vertical blank
- HB  in  1  horizontal blank
- pal_base  in  16  palette base register; VRAM byte address = pal_base<<8
- pal_copy  in  1  one-cycle pulse; arms a palette copy
- pxl_in  in  PAL_AW  palette index from mixer
- vram_addr  out  23  word address [23:1] to VRAM slot
- vram_cs  out  1  VRAM request
- vram_data  in  16  VRAM read data
- vram_ok  in  1  VRAM data valid
- pal_busy  out  1  high while DMA is active
- red  out  8  red output
- green  out  8  green output
- blue  out  8  blue output

Behaviour:
- Reset: applied on a clk edge with rst=1.
  - vram_cs=0, vram_addr=0, pal_busy=0, red/green/blue=0.
  - Arm flag cleared; FSM to IDLE.
  - Palette RAM contents are not cleared.
- Arm:
  - pal_copy=1 sets arm; pal_base is sampled into base_l on that cycle.
  - pal_copy during a copy re-arms for the next VB rising edge.
  - The running copy keeps its original base.
- VB rising edge: detected as VB=1 while the registered VB=0, on clk, independent of pxl_cen.
- FSM states:
  - IDLE: on VB rising edge with arm=1 → clear arm, cnt=0, pal_busy=1, go to REQ. If pal_copy coincides with the edge, arm stays set for the next frame.
  - REQ:
    - vram_cs=1, vram_addr={base_l,7'd0}+cnt (23-bit, wraps modulo 2**23).
    - Address is held stable until vram_ok=1 is sampled.
    - On that cycle: write vram_data to palette[cnt]; go to GAP.
  - GAP:
    - vram_cs=0 for exactly one cycle; vram_ok is ignored here.
    - If cnt==2**PAL_AW-1 → DONE, else cnt+=1 → REQ.
  - DONE: pal_busy=0, go to IDLE.
- The copy is not aborted by VB falling; it runs to completion.
- Palette word format: [15:12] brightness br, [11:8] R, [7:4] G, [3:0] B.
- Pixel pipeline, advancing only on pxl_cen:
  - Stage 1: register pxl_in and blank=HB|VB; palette RAM read address = registered index.
  - Stage 2: out = (c*(br+16))>>1 for each channel.
    - 9-bit intermediate; max 15*31=465 → 232 fits 8 bits.
    - If the delayed blank=1, outputs are 0.
  - Latency: 2 pxl_cen pulses from pxl_in/HB/VB to red/green/blue. Outputs hold between cens.
- Simultaneous DMA write and pixel read at the same address: the read returns the old value; the write is never lost.
- pal_copy while rst=1: ignored.

Test Plan:
1. Reset values: rst=1 for 3 clk with pxl_cen active → red=green=blue=0, vram_cs=0, pal_busy=0; after release with no pal_copy, a VB rising edge → no vram_cs.
2. Full copy: VRAM word i at 0x48_0000+i = i ^ 16'hF0F0, pal_base=16'h9000, pal_copy pulse, then VB↑.
   - vram_addr first 23'h48_0000, last 23'h48_07FF.
   - 2048 requests, each separated by a one-cycle vram_cs=0 gap.
   - pal_busy falls after the last word.
3. Random-latency slot:
   - vram_ok delayed 1–8 cycles → vram_addr stable while vram_cs=1.
   - A spurious vram_ok during GAP → no write and no count advance.
   - Palette readback matches VRAM.
4. Colour math and latency, pxl_in=5:
   - palette[5]=16'hFF00 → red=232, green=0, blue=0 exactly 2 pxl_cen later.
   - palette[5]=16'h0888 → each channel (8*16)>>1=64.
   - HB=1 → outputs 0 after the same 2-cen latency.
5. Arm timing:
   - pal_copy during an active copy → a second copy starts on the next VB↑, not the current one.
   - pal_copy coincident with VB↑ while IDLE and disarmed → copy on the following frame.
6. Reset mid-copy: rst at word 100 → vram_cs=0, IDLE next cycle; palette[0..99] keep the new values; no further requests without a new pal_copy and VB↑.

Source files
------------

// File: rtl/jtcps1_colour.sv
// rtl/jtcps1_colour.sv - palette DMA from VRAM and palette-indexed pixel colour stage
//
// Purpose
//   Sits after the tilemap/sprite mixer. Holds a 2**PAL_AW x 16-bit palette
//   RAM. The RAM is refilled from VRAM by a small DMA engine when a copy has
//   been armed and vertical blank begins. Every pixel index is looked up in
//   the palette and turned into brightness-scaled 8-bit RGB, with blanking
//   forcing black.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   pxl_cen         pixel clock enable; the pixel pipeline only moves on it
//   VB, HB          vertical / horizontal blank
//   pal_base        palette base register (VRAM byte address = pal_base<<8)
//   pal_copy        one-cycle pulse that arms a palette copy
//   pxl_in          palette index from the mixer
//   vram_addr       VRAM word address [23:1] for the SDRAM mux read slot
//   vram_cs         VRAM read request, held until vram_ok
//   vram_data       VRAM read data, valid with vram_ok
//   vram_ok         VRAM data valid
//   pal_busy        high while the DMA is transferring words
//   red/green/blue  8-bit colour outputs, two pxl_cen pulses after pxl_in

module jtcps1_colour #(
    parameter int PAL_AW = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pxl_cen,
    input  logic              VB,
    input  logic              HB,
    input  logic [15:0]       pal_base,
    input  logic              pal_copy,
    input  logic [PAL_AW-1:0] pxl_in,
    output logic [23:1]       vram_addr,
    output logic              vram_cs,
    input  logic [15:0]       vram_data,
    input  logic              vram_ok,
    output logic              pal_busy,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue
);

    localparam int PAL_SIZE = 1 << PAL_AW;
    localparam logic [PAL_AW-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [PAL_AW-1:0] cnt, cnt_nxt;
    logic              arm, arm_nxt;
    // base_l follows the latest pal_copy; base_cp is frozen for the running
    // copy so a re-arm mid-transfer cannot redirect words already in flight.
    logic [15:0]       base_l, base_l_nxt;
    logic [15:0]       base_cp, base_cp_nxt;
    logic              vb_l;
    logic              vb_rise;
    logic              pal_we;

    logic [15:0]       pal_ram [PAL_SIZE];
    logic [15:0]       pal_rd;

    logic [PAL_AW-1:0] idx_l;
    logic              blank_l;

    // ------------------------------------------------------------------
    // DMA control
    // ------------------------------------------------------------------

    // vb_l tracks VB even in reset so a blank already in progress when
    // reset is released does not look like a fresh rising edge.
    always_ff @(posedge clk) begin
        vb_l <= VB;
    end

    assign vb_rise = VB & ~vb_l;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            arm     <= 1'b0;
            base_l  <= 16'd0;
            base_cp <= 16'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            arm     <= arm_nxt;
            base_l  <= base_l_nxt;
            base_cp <= base_cp_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        arm_nxt     = arm;
        base_l_nxt  = base_l;
        base_cp_nxt = base_cp;

        if (pal_copy) begin
            arm_nxt    = 1'b1;
            base_l_nxt = pal_base;
        end

        case (state)
            IDLE: begin
                if (vb_rise && arm) begin
                    state_nxt   = REQ;
                    cnt_nxt     = '0;
                    base_cp_nxt = base_l;
                    // A pal_copy landing on the same edge arms the next frame.
                    if (!pal_copy) begin
                        arm_nxt = 1'b0;
                    end
                end
            end
            REQ: begin
                if (vram_ok) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                // One idle cycle lets the SDRAM mux drop its ok strobe before
                // the next request; any ok seen here is ignored.
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = REQ;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request outputs are decoded from the state register, so the address
    // cannot move while REQ waits for vram_ok.
    always_comb begin
        vram_cs   = 1'b0;
        vram_addr = '0;
        if (state == REQ) begin
            vram_cs   = 1'b1;
            vram_addr = {base_cp, 7'd0} + 23'(cnt);
        end
    end

    assign pal_busy = (state == REQ) || (state == GAP);
    assign pal_we   = !rst && (state == REQ) && vram_ok;

    // ------------------------------------------------------------------
    // Palette RAM: DMA write port, pixel read port. The read is taken in
    // the same clock as a possible write, so a collision returns the old
    // word while the new word still lands.
    // ------------------------------------------------------------------

    always_ff @(posedge clk) begin
        if (pal_we) begin
            pal_ram[cnt] <= vram_data;
        end
    end

    assign pal_rd = pal_ram[idx_l];

    // ------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------

    // c*(br+16) is at most 15*31 = 465 (9 bits); dropping the LSB gives 232.
    function automatic logic [7:0] scale(input logic [3:0] c, input logic [3:0] br);
        logic [8:0] prod;
        prod = 9'(c) * (9'(br) + 9'd16);
        return prod[8:1];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_l   <= '0;
            blank_l <= 1'b0;
            red     <= 8'd0;
            green   <= 8'd0;
            blue    <= 8'd0;
        end else if (pxl_cen) begin
            idx_l   <= pxl_in;
            blank_l <= HB | VB;
            if (blank_l) begin
                red   <= 8'd0;
                green <= 8'd0;
                blue  <= 8'd0;
            end else begin
                red   <= scale(pal_rd[11:8], pal_rd[15:12]);
                green <= scale(pal_rd[7:4],  pal_rd[15:12]);
                blue  <= scale(pal_rd[3:0],  pal_rd[15:12]);
            end
        end
    end

endmodule

// File: tb/tb_jtcps1_colour.sv
// tb/tb_jtcps1_colour.sv - directed bench for jtcps1_colour

module tb_jtcps1_colour;

    logic        clk = 1'b0;
    logic        rst;
    logic        pxl_cen;
    logic        VB;
    logic        HB;
    logic [15:0] pal_base;
    logic        pal_copy;
    logic [10:0] pxl_in;
    logic [23:1] vram_addr;
    logic        vram_cs;
    logic [15:0] vram_data = 16'd0;
    logic        vram_ok = 1'b0;
    logic        pal_busy;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;

    jtcps1_colour #(.PAL_AW(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .pxl_cen   (pxl_cen),
        .VB        (VB),
        .HB        (HB),
        .pal_base  (pal_base),
        .pal_copy  (pal_copy),
        .pxl_in    (pxl_in),
        .vram_addr (vram_addr),
        .vram_cs   (vram_cs),
        .vram_data (vram_data),
        .vram_ok   (vram_ok),
        .pal_busy  (pal_busy),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // VRAM contents indexed by the low 11 word-address bits (bases are
    // chosen 2048-word aligned).
    logic [15:0] vmem [0:2047];

    // Slot model / monitor state
    int          reqs = 0;
    int          gap_bad = 0;
    int          addr_bad = 0;
    int          zero_run = 0;
    int          dly = 0;
    int          lat_max = 1;
    bit          spur_en = 1'b0;
    bit          spur_now = 1'b0;
    logic        prev_cs = 1'b0;
    logic        prev_busy = 1'b0;
    logic [23:1] prev_addr = '0;
    logic [23:1] last_addr = '0;

    always @(negedge clk) begin
        if (vram_cs) begin
            if (!prev_cs) begin
                reqs++;
                if (prev_busy && zero_run != 1) gap_bad++;
            end else if (vram_addr != prev_addr) begin
                addr_bad++;
            end
            last_addr = vram_addr;
            zero_run  = 0;
        end else begin
            zero_run++;
        end
        prev_cs   = vram_cs;
        prev_busy = pal_busy;
        prev_addr = vram_addr;

        if (vram_ok) begin
            if (spur_en && !spur_now) begin
                spur_now  = 1'b1;
                vram_data = 16'hDEAD;
            end else begin
                vram_ok  = 1'b0;
                spur_now = 1'b0;
                dly      = (lat_max > 1) ? int'($urandom_range(lat_max - 1, 0)) : 0;
            end
        end else if (vram_cs) begin
            if (dly == 0) begin
                vram_ok   = 1'b1;
                vram_data = vmem[vram_addr[11:1]];
            end else begin
                dly--;
            end
        end
    end

    function automatic logic [23:0] colour(input logic [15:0] w);
        int s;
        s = int'(w[15:12]) + 16;
        return {8'((int'(w[11:8]) * s) >> 1),
                8'((int'(w[7:4])  * s) >> 1),
                8'((int'(w[3:0])  * s) >> 1)};
    endfunction

    function automatic logic [15:0] p5(input int i);
        return 16'(i * 3) + 16'h1111;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cen_tick;
        pxl_cen = 1'b1;
        tick(1);
        pxl_cen = 1'b0;
        tick(1);
    endtask

    task automatic pix(input int idx, output logic [23:0] rgb);
        pxl_in = 11'(idx);
        cen_tick;
        cen_tick;
        rgb = {red, green, blue};
    endtask

    task automatic arm(input logic [15:0] base);
        pal_base = base;
        pal_copy = 1'b1;
        tick(1);
        pal_copy = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 40000 && pal_busy; k++) tick(1);
        check({tag, "_done"}, 32'(pal_busy), 32'd0);
    endtask

    task automatic run_copy(input string tag, input logic [15:0] base,
                            input logic [23:1] exp_first, input int lat);
        int r0, g0, a0;
        lat_max = lat;
        r0 = reqs;
        g0 = gap_bad;
        a0 = addr_bad;
        arm(base);
        VB = 1'b0;
        tick(1);
        VB = 1'b1;
        tick(1);
        check({tag, "_busy"}, 32'(pal_busy), 32'd1);
        check({tag, "_first"}, 32'(vram_addr), 32'(exp_first));
        wait_done(tag);
        VB = 1'b0;
        check({tag, "_last"}, 32'(last_addr), 32'(exp_first + 23'd2047));
        check({tag, "_reqs"}, 32'(reqs - r0), 32'd2048);
        check({tag, "_gap"}, 32'(gap_bad - g0), 32'd0);
        check({tag, "_stable"}, 32'(addr_bad - a0), 32'd0);
    endtask

    initial begin
        int          r0, r1, bad;
        logic [23:0] rgb;
        logic [23:0] exp_rgb;

        rst = 1'b1; pxl_cen = 1'b1; VB = 1'b0; HB = 1'b0;
        pal_copy = 1'b0; pal_base = 16'd0; pxl_in = 11'd0;
        for (int i = 0; i < 2048; i++) vmem[i] = 16'd0;

        // Reset values
        tick(3);
        check("rst_rgb", 32'({red, green, blue}), 32'd0);
        check("rst_cs", 32'(vram_cs), 32'd0);
        check("rst_busy", 32'(pal_busy), 32'd0);
        check("rst_addr", 32'(vram_addr), 32'd0);
        rst = 1'b0;
        pxl_cen = 1'b0;
        r0 = reqs;
        VB = 1'b1;
        tick(20);
        VB = 1'b0;
        check("noarm_reqs", 32'(reqs - r0), 32'd0);
        check("noarm_busy", 32'(pal_busy), 32'd0);

        // Full copy, fixed one-cycle latency
        for (int i = 0; i < 2048; i++) vmem[i] = 16'(i) ^ 16'hF0F0;
        run_copy("full", 16'h9000, 23'h48_0000, 1);
        check("full_last_hand", 32'(last_addr), 32'h0048_07FF);

        // Random latency with spurious ok in GAP
        for (int i = 0; i < 2048; i++) vmem[i] = 16'(i * 16'h02F1) ^ 16'h5A3C;
        spur_en = 1'b1;
        run_copy("rand", 16'h1230, 23'h09_1800, 8);
        spur_en = 1'b0;
        lat_max = 1;
        pix(0, rgb);
        check("rand_pal0", 32'(rgb), 32'({8'd105, 8'd31, 8'd126}));
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            pix(i, rgb);
            if (rgb !== colour(vmem[i])) bad++;
        end
        check("rand_readback", 32'(bad), 32'd0);

        // Colour math and two-cen latency
        for (int i = 0; i < 2048; i++) vmem[i] = 16'd0;
        vmem[5] = 16'hFF00;
        run_copy("c4a", 16'h0010, 23'h00_0800, 1);
        pix(4, rgb);
        check("lat_pre", 32'(rgb), 32'd0);
        pxl_in = 11'd5;
        cen_tick;
        check("lat_1cen", 32'({red, green, blue}), 32'd0);
        cen_tick;
        check("lat_2cen", 32'({red, green, blue}), 32'({8'd232, 8'd0, 8'd0}));
        tick(3);
        check("lat_hold", 32'({red, green, blue}), 32'({8'd232, 8'd0, 8'd0}));
        HB = 1'b1;
        cen_tick;
        check("hb_1cen", 32'({red, green, blue}), 32'({8'd232, 8'd0, 8'd0}));
        cen_tick;
        check("hb_2cen", 32'({red, green, blue}), 32'd0);
        HB = 1'b0;
        vmem[5] = 16'h0888;
        run_copy("c4b", 16'h0010, 23'h00_0800, 1);
        pix(5, rgb);
        check("c4b_rgb", 32'(rgb), 32'({8'd64, 8'd64, 8'd64}));

        // Re-arm during an active copy
        for (int i = 0; i < 2048; i++) vmem[i] = p5(i);
        r0 = reqs;
        arm(16'h0020);
        VB = 1'b1;
        tick(1);
        check("rearm_a_busy", 32'(pal_busy), 32'd1);
        tick(100);
        arm(16'h0030);
        wait_done("rearm_a");
        check("rearm_a_last", 32'(last_addr), 32'h0000_17FF);
        r1 = reqs;
        tick(10);
        check("rearm_not_now", 32'(reqs - r1), 32'd0);
        check("rearm_a_reqs", 32'(r1 - r0), 32'd2048);
        VB = 1'b0;
        tick(1);
        VB = 1'b1;
        tick(1);
        check("rearm_b_busy", 32'(pal_busy), 32'd1);
        check("rearm_b_first", 32'(vram_addr), 32'h0000_1800);
        wait_done("rearm_b");
        VB = 1'b0;

        // pal_copy coincident with VB rising while disarmed
        for (int i = 0; i < 2048; i++) vmem[i] = ~p5(i);
        tick(3);
        r0 = reqs;
        VB = 1'b1;
        pal_copy = 1'b1;
        pal_base = 16'h0040;
        tick(1);
        pal_copy = 1'b0;
        check("coin_idle", 32'(pal_busy), 32'd0);
        tick(5);
        check("coin_noreq", 32'(reqs - r0), 32'd0);
        VB = 1'b0;
        tick(1);
        VB = 1'b1;
        tick(1);
        check("coin_next_busy", 32'(pal_busy), 32'd1);
        check("coin_next_first", 32'(vram_addr), 32'h0000_2000);

        // Reset in the middle of that copy
        for (int k = 0; k < 5000 && (reqs - r0) < 101; k++) tick(1);
        check("mid_reach", 32'((reqs - r0) >= 101), 32'd1);
        rst = 1'b1;
        pal_copy = 1'b1;
        pal_base = 16'h0050;
        tick(1);
        rst = 1'b0;
        pal_copy = 1'b0;
        check("mid_cs", 32'(vram_cs), 32'd0);
        check("mid_busy", 32'(pal_busy), 32'd0);
        r1 = reqs;
        VB = 1'b0;
        tick(1);
        VB = 1'b1;
        tick(20);
        VB = 1'b0;
        check("mid_noreq", 32'(reqs - r1), 32'd0);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (i != 100) begin
                pix(i, rgb);
                exp_rgb = (i < 100) ? colour(~p5(i)) : colour(p5(i));
                if (rgb !== exp_rgb) bad++;
            end
        end
        check("mid_readback", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
